// File: rtl/traffic_phase_timer_ctrl.sv
// traffic_phase_timer_ctrl
//   Two-road intersection controller. Per-phase timers run off a clock
//   prescaler. Adds latched pedestrian service, a timed emergency all-red
//   flash and a power-outage yellow flash.
// Ports
//   clk, rst_n    : system clock, asynchronous active-low reset
//   emergency     : emergency request (level)
//   power_outage  : outage mode (level)
//   ped_req       : pedestrian button (pulse, latched)
//   light1/light2 : road heads {R,Y,G}
//   walk          : pedestrian walk lamp
//   state         : current state code (debug)
module traffic_phase_timer_ctrl #(
   parameter int unsigned TICK_DIV  = 50_000_000,
   parameter int unsigned GREEN_T   = 20,
   parameter int unsigned GREEN_MIN = 5,
   parameter int unsigned YELLOW_T  = 3,
   parameter int unsigned ALLRED_T  = 1,
   parameter int unsigned PED_T     = 10,
   parameter int unsigned FLASH_T   = 1,
   parameter int unsigned EMERG_T   = 20
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       emergency,
   input  logic       power_outage,
   input  logic       ped_req,
   output logic [2:0] light1,
   output logic [2:0] light2,
   output logic       walk,
   output logic [3:0] state
);

   localparam int unsigned PS_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned MAX_A = (GREEN_T > YELLOW_T) ? GREEN_T : YELLOW_T;
   localparam int unsigned MAX_B = (ALLRED_T > PED_T) ? ALLRED_T : PED_T;
   localparam int unsigned MAX_C = (FLASH_T > EMERG_T) ? FLASH_T : EMERG_T;
   localparam int unsigned MAX_D = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int unsigned MAX_T = (MAX_D > MAX_C) ? MAX_D : MAX_C;
   localparam int unsigned PH_W  = (MAX_T > 1) ? $clog2(MAX_T) : 1;

   localparam logic [2:0] L_RED = 3'b100;
   localparam logic [2:0] L_YEL = 3'b010;
   localparam logic [2:0] L_GRN = 3'b001;
   localparam logic [2:0] L_OFF = 3'b000;

   typedef enum logic [3:0] {
      S_G2     = 4'd0,
      S_Y2     = 4'd1,
      S_AR     = 4'd2,
      S_G1     = 4'd3,
      S_Y1     = 4'd4,
      S_WALK   = 4'd6,
      S_EMERG  = 4'd7,
      S_OUTAGE = 4'd8
   } state_t;

   state_t          st;
   state_t          st_nxt_c;
   logic [PS_W-1:0] presc;
   logic [PH_W-1:0] ph_cnt;
   logic [PH_W-1:0] fl_cnt;
   logic            fl_on;
   logic            ped_pend;
   logic            walk_next;   // AR currently in progress leads into WALK
   logic            road2;       // next green goes to road 2
   logic            tick_c;
   logic            ph_done_c;
   logic            green_cut_c;
   logic            enter_c;
   logic            fl_on_nxt_c;
   logic [2:0]      l1_nxt_c;
   logic [2:0]      l2_nxt_c;

   assign state = 4'(st);

   // Phase length minus one, loaded on entry to a state
   function automatic logic [PH_W-1:0] phase_len(input state_t s);
      logic [PH_W-1:0] v;
      case (s)
         S_G1, S_G2: v = PH_W'(GREEN_T - 1);
         S_Y1, S_Y2: v = PH_W'(YELLOW_T - 1);
         S_WALK:     v = PH_W'(PED_T - 1);
         S_EMERG:    v = PH_W'(EMERG_T - 1);
         default:    v = PH_W'(ALLRED_T - 1);
      endcase
      return v;
   endfunction

   assign tick_c    = (presc == PS_W'(TICK_DIV - 1));
   assign ph_done_c = tick_c && (ph_cnt == '0);
   // A pending ped request ends green once GREEN_MIN ticks have elapsed
   assign green_cut_c = ped_pend && (ph_cnt <= PH_W'(GREEN_T - GREEN_MIN));

   // Next-state selection, preemption applied last
   always_comb begin
      st_nxt_c = st;
      case (st)
         S_G2:     if (tick_c && ((ph_cnt == '0) || green_cut_c)) st_nxt_c = S_Y2;
         S_Y2:     if (ph_done_c) st_nxt_c = S_AR;
         S_AR:     if (ph_done_c) st_nxt_c = walk_next ? S_WALK : (road2 ? S_G2 : S_G1);
         S_G1:     if (tick_c && ((ph_cnt == '0) || green_cut_c)) st_nxt_c = S_Y1;
         S_Y1:     if (ph_done_c) st_nxt_c = S_AR;
         S_WALK:   if (ph_done_c) st_nxt_c = S_AR;
         S_EMERG:  if (ph_done_c && !emergency) st_nxt_c = S_AR;
         S_OUTAGE: if (!power_outage) st_nxt_c = S_AR;
         default:  st_nxt_c = S_AR;
      endcase
      if (emergency)
         st_nxt_c = S_EMERG;
      else if (power_outage && (st != S_EMERG))
         st_nxt_c = S_OUTAGE;
   end

   assign enter_c = (st_nxt_c != st);

   // Flash phase restarts "on" at every entry, toggles every FLASH_T ticks
   assign fl_on_nxt_c = enter_c ? 1'b1 :
                        ((tick_c && (fl_cnt == '0)) ? ~fl_on : fl_on);

   // Head decode for the state being entered so lights move with state
   always_comb begin
      l1_nxt_c = L_RED;
      l2_nxt_c = L_RED;
      case (st_nxt_c)
         S_G2: l2_nxt_c = L_GRN;
         S_Y2: l2_nxt_c = L_YEL;
         S_G1: l1_nxt_c = L_GRN;
         S_Y1: l1_nxt_c = L_YEL;
         S_EMERG: begin
            l1_nxt_c = fl_on_nxt_c ? L_RED : L_OFF;
            l2_nxt_c = fl_on_nxt_c ? L_RED : L_OFF;
         end
         S_OUTAGE: begin
            l1_nxt_c = fl_on_nxt_c ? L_YEL : L_OFF;
            l2_nxt_c = fl_on_nxt_c ? L_YEL : L_OFF;
         end
         default: ;
      endcase
   end

   // State, timers and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st        <= S_AR;
         presc     <= '0;
         ph_cnt    <= PH_W'(ALLRED_T - 1);
         fl_cnt    <= PH_W'(FLASH_T - 1);
         fl_on     <= 1'b1;
         ped_pend  <= 1'b0;
         walk_next <= 1'b0;
         road2     <= 1'b1;
         light1    <= L_RED;
         light2    <= L_RED;
         walk      <= 1'b0;
      end else begin
         st     <= st_nxt_c;
         fl_on  <= fl_on_nxt_c;
         light1 <= l1_nxt_c;
         light2 <= l2_nxt_c;
         walk   <= (st_nxt_c == S_WALK);

         if ((st_nxt_c == S_WALK) && (st != S_WALK))
            ped_pend <= 1'b0;
         else if (ped_req && (st != S_WALK))
            ped_pend <= 1'b1;

         if (enter_c) begin
            presc  <= '0;
            ph_cnt <= phase_len(st_nxt_c);
            fl_cnt <= PH_W'(FLASH_T - 1);
            if ((st_nxt_c == S_EMERG) || (st_nxt_c == S_OUTAGE)) begin
               road2     <= 1'b1;
               walk_next <= 1'b0;
            end else if (st_nxt_c == S_WALK) begin
               walk_next <= 1'b0;
            end else if ((st_nxt_c == S_AR) && ((st == S_Y1) || (st == S_Y2))) begin
               road2     <= ~road2;
               walk_next <= ped_pend;
            end
         end else begin
            presc <= tick_c ? '0 : presc + PS_W'(1);
            // Emergency hold timer only starts counting once the request drops
            if ((st == S_EMERG) && emergency)
               ph_cnt <= PH_W'(EMERG_T - 1);
            else if (tick_c && (ph_cnt != '0))
               ph_cnt <= ph_cnt - PH_W'(1);
            if (tick_c)
               fl_cnt <= (fl_cnt == '0) ? PH_W'(FLASH_T - 1) : fl_cnt - PH_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_traffic_phase_timer_ctrl.sv
`timescale 1ns/1ps
// Bench for traffic_phase_timer_ctrl. Expected output segments (state,
// heads, walk, length in cycles) are queued by the stimulus; the monitor
// samples every falling edge and compares each finished segment.
module tb_traffic_phase_timer_ctrl;

   localparam logic [2:0] R = 3'b100;
   localparam logic [2:0] Y = 3'b010;
   localparam logic [2:0] G = 3'b001;
   localparam logic [2:0] O = 3'b000;
   localparam logic [3:0] SG2 = 4'd0, SY2 = 4'd1, SAR = 4'd2, SG1 = 4'd3,
                          SY1 = 4'd4, SWK = 4'd6, SEM = 4'd7, SOU = 4'd8;

   typedef struct packed {
      logic [3:0]  st;
      logic [2:0]  l1;
      logic [2:0]  l2;
      logic        w;
      logic [15:0] len;
   } seg_t;

   logic       clk;
   logic       rst_n;
   logic       emergency;
   logic       power_outage;
   logic       ped_req;
   logic [2:0] light1;
   logic [2:0] light2;
   logic       walk;
   logic [3:0] state;

   int   checks = 0;
   int   errors = 0;
   seg_t exp_q[$];

   traffic_phase_timer_ctrl #(
      .TICK_DIV (4),
      .GREEN_T  (5),
      .GREEN_MIN(2),
      .YELLOW_T (2),
      .ALLRED_T (1),
      .PED_T    (3),
      .FLASH_T  (1),
      .EMERG_T  (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .emergency   (emergency),
      .power_outage(power_outage),
      .ped_req     (ped_req),
      .light1      (light1),
      .light2      (light2),
      .walk        (walk),
      .state       (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic push(input logic [3:0] s, input logic [2:0] a, input logic [2:0] b,
                       input logic w, input int n);
      seg_t e;
      e.st = s; e.l1 = a; e.l2 = b; e.w = w; e.len = 16'(n);
      exp_q.push_back(e);
   endtask

   // Emergency flash: n pairs of red/off, each 4 cycles
   task automatic push_em(input int pairs);
      for (int i = 0; i < pairs; i++) begin
         push(SEM, R, R, 1'b0, 4);
         push(SEM, O, O, 1'b0, 4);
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Drive point: 2 ns after falling edge number s (time 10*s)
   task automatic at_smp(input int s);
      longint t;
      t = longint'(s) * 10 + 2;
      if (longint'($time) < t) #(t - longint'($time));
   endtask

   // Monitor: accumulate run lengths of identical output tuples
   initial begin
      logic [10:0] cur;
      logic [10:0] t;
      int          len;
      int          idx;
      bit          have;
      seg_t        e;
      have = 1'b0;
      len  = 0;
      idx  = 0;
      cur  = '0;
      forever begin
         @(negedge clk);
         t = {state, light1, light2, walk};
         if (!have) begin
            have = 1'b1;
            cur  = t;
            len  = 1;
         end else if (t == cur) begin
            len++;
         end else begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL seg%0d unexpected st=%0d l1=%b l2=%b w=%b len=%0d",
                        idx, cur[10:7], cur[6:4], cur[3:1], cur[0], len);
            end else begin
               e = exp_q.pop_front();
               if (({e.st, e.l1, e.l2, e.w} != cur) || (int'(e.len) != len)) begin
                  errors++;
                  $display("FAIL seg%0d got st=%0d l1=%b l2=%b w=%b len=%0d expected st=%0d l1=%b l2=%b w=%b len=%0d",
                           idx, cur[10:7], cur[6:4], cur[3:1], cur[0], len,
                           e.st, e.l1, e.l2, e.w, e.len);
               end
            end
            idx++;
            cur = t;
            len = 1;
         end
      end
   end

   initial begin
      rst_n        = 1'b0;
      emergency    = 1'b0;
      power_outage = 1'b0;
      ped_req      = 1'b0;

      // Normal cycle; the first AR also covers the 3 samples taken in reset
      push(SAR, R, R, 1'b0, 6);
      push(SG2, R, G, 1'b0, 20);
      push(SY2, R, Y, 1'b0, 8);
      push(SAR, R, R, 1'b0, 4);
      push(SG1, G, R, 1'b0, 20);
      push(SY1, Y, R, 1'b0, 8);
      push(SAR, R, R, 1'b0, 4);
      at_smp(2);
      chk("rst_state",  32'(state),  32'd2);
      chk("rst_light1", 32'(light1), 32'(R));
      chk("rst_light2", 32'(light2), 32'(R));
      chk("rst_walk",   32'(walk),   32'd0);
      at_smp(3);
      rst_n = 1'b1;

      // Ped request early in G2: green cut at GREEN_MIN, then walk, then G1
      push(SG2, R, G, 1'b0, 8);
      push(SY2, R, Y, 1'b0, 8);
      push(SAR, R, R, 1'b0, 4);
      push(SWK, R, R, 1'b1, 12);
      push(SAR, R, R, 1'b0, 4);
      at_smp(72);
      ped_req = 1'b1;
      at_smp(73);
      ped_req = 1'b0;

      // Emergency pulse mid-Y1
      push(SG1, G, R, 1'b0, 20);
      push(SY1, Y, R, 1'b0, 4);
      push_em(2);
      push(SAR, R, R, 1'b0, 4);
      push(SG2, R, G, 1'b0, 20);
      push(SY2, R, Y, 1'b0, 8);
      push(SAR, R, R, 1'b0, 4);
      at_smp(130);
      emergency = 1'b1;
      at_smp(131);
      emergency = 1'b0;

      // Outage during G1, emergency arrives 10 cycles later
      push(SG1, G, R, 1'b0, 3);
      push(SOU, Y, Y, 1'b0, 4);
      push(SOU, O, O, 1'b0, 4);
      push(SOU, Y, Y, 1'b0, 2);
      push_em(4);
      push(SEM, R, R, 1'b0, 4);
      push(SAR, R, R, 1'b0, 4);
      push(SG2, R, G, 1'b0, 20);
      push(SY2, R, Y, 1'b0, 8);
      push(SAR, R, R, 1'b0, 4);
      at_smp(185);
      power_outage = 1'b1;
      at_smp(195);
      emergency = 1'b1;
      at_smp(215);
      power_outage = 1'b0;
      at_smp(216);
      emergency = 1'b0;

      // Reset in the middle of WALK; afterwards G2 runs full length
      push(SG1, G, R, 1'b0, 8);
      push(SY1, Y, R, 1'b0, 8);
      push(SAR, R, R, 1'b0, 4);
      push(SWK, R, R, 1'b1, 5);
      push(SAR, R, R, 1'b0, 6);
      push(SG2, R, G, 1'b0, 20);
      push(SY2, R, Y, 1'b0, 8);
      push(SAR, R, R, 1'b0, 4);
      push(SG1, G, R, 1'b0, 20);
      push(SY1, Y, R, 1'b0, 8);
      push(SAR, R, R, 1'b0, 4);
      at_smp(270);
      ped_req = 1'b1;
      at_smp(271);
      ped_req = 1'b0;
      at_smp(292);
      rst_n = 1'b0;
      #1;
      chk("arst_state",  32'(state),  32'd2);
      chk("arst_light1", 32'(light1), 32'(R));
      chk("arst_light2", 32'(light2), 32'(R));
      chk("arst_walk",   32'(walk),   32'd0);
      at_smp(295);
      rst_n = 1'b1;

      // Ped and emergency together in G2: pending ped survives the emergency
      push(SG2, R, G, 1'b0, 3);
      push_em(2);
      push(SAR, R, R, 1'b0, 4);
      push(SG2, R, G, 1'b0, 8);
      push(SY2, R, Y, 1'b0, 8);
      push(SAR, R, R, 1'b0, 4);
      push(SWK, R, R, 1'b1, 12);
      push(SAR, R, R, 1'b0, 4);
      at_smp(365);
      ped_req   = 1'b1;
      emergency = 1'b1;
      at_smp(366);
      ped_req   = 1'b0;
      emergency = 1'b0;

      for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain remaining=%0d expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
